as5600_target: RTL and testbench
================================

# as5600_target

I2C target (responder) that emulates the AS5600 magnetic encoder's read path. An on-chip I2C initiator, or an external host, can read a 12-bit angle supplied by fabric logic over the same 2-wire bus and register addresses the real sensor uses. It sits on the encoder-side bus of the swerve subsystem and is used both as a bench/loopback model for the angle-reading initiator and as a hardware stand-in when no sensor is fitted.

## Interface
Parameters:
- DEV_ADDR, 7'h36, 7-bit target address; the write header is 8'h6C and the read header is 8'h6D.

Ports:
- clock  input  1  main clock. Single clock domain; one clock, as decided for this block.
- reset_n  input  1  reset, asynchronous assert, active-low. Asynchronous and active-low, as decided for this block.
- angle_in  input  12  angle value to serve.
- angle_valid  input  1  when high, angle_in is captured into the live angle register each cycle.
- scl  input  1  I2C clock. Asynchronous to clock; never driven by this block.
- sda  inout  1  I2C data. Open-drain: either driven 1'b0 or left at 1'bZ, never driven 1.
- busy  output  1  high from an address-matched START until STOP or the next START.
- rd_done  output  1  one-cycle pulse on STOP if at least one data byte was read in the transaction.
- reg_ptr  output  8  current register pointer, for debug.

## Operation
- **Input sync:** scl and sda pass through a 2-flop synchronizer, then a 1-flop edge detect.
  - START = sda fall while scl high; STOP = sda rise while scl high.
  - Data is sampled on scl rise and changed only after scl fall.
- **Register map** (all read-only):
  - 0x0B = 8'h20 (status: magnet detected).
  - 0x0C = {4'h0, snap[11:8]}; 0x0D = snap[7:0].
  - 0x0E and 0x0F mirror 0x0C and 0x0D.
  - Any other address reads 8'h00.
- **Snapshot:** the live angle is copied into snap[11:0] on every matched read header, so high and low bytes are always coherent.
- **States:** IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WR_DISCARD, WR_ACK, RD_DATA, RD_ACK, IGNORE.
  - IDLE: START -> ADDR, bit counter cleared.
  - ADDR: shift 8 bits MSB-first.
    - On a match: R/W=0 -> ADDR_ACK then REG; R/W=1 -> ADDR_ACK then RD_DATA.
    - No match -> IGNORE, with sda never driven.
  - REG: 8 bits are loaded into reg_ptr, then REG_ACK -> WR_DISCARD.
  - WR_DISCARD: further written bytes are ACKed (WR_ACK) and dropped; the pointer does not move.
  - RD_DATA: the byte at reg_ptr is shifted out MSB-first.
    - reg_ptr increments after the 8th bit, wrapping 8'hFF -> 8'h00.
    - RD_ACK samples the initiator's ACK bit. ACK (0) -> RD_DATA for the next byte; NACK (1) -> IGNORE, with sda released.
  - From any state: START (including a repeated START) -> ADDR; STOP -> IDLE.
- **ACK drive:** in *_ACK states, sda is held low from the scl fall after bit 8 until the next scl fall.
- **Pointer persistence:** reg_ptr persists across transactions, so a read without a pointer write continues from the last pointer.

## Timing
- **Reset values:** sda released (Z), busy=0, rd_done=0, reg_ptr=8'h00, snap=0, live angle=0, state IDLE.
- **Async reset mid-transfer:** releases sda immediately, with no clock needed.
- **Pin-to-internal latency:** 3 clocks. The scl high and low periods must each be ≥ 6 clocks; the bench drives scl at clock/16.
- **sda drive timing:** sda changes 1 clock after the synchronized scl fall, and is therefore stable well before the next scl rise.
- **busy:** rises 1 clock after the detected START is matched at ADDR_ACK entry. Falls 1 clock after STOP/START detection.
- **rd_done:** asserted the cycle after STOP is detected.
- **Simultaneous events:** START/STOP detection has priority over any bit shift in the same cycle. An angle_valid update in the same cycle as the snapshot update yields the pre-update live value.

## Test plan
- **Pointer write then read:** angle_in=12'hABC with valid; initiator sends START, 6C, 0C, repeated START, 6D, reads 2 bytes, ACK then NACK, STOP.
  - Required: ACK on all 3 header/pointer bytes; data 8'h0A, 8'hBC; rd_done pulses once; reg_ptr=8'h0E.
- **Wrong address:** START, 8'hA0.
  - Required: sda never driven low through STOP; busy stays 0.
- **Snapshot coherence:** angle_in=12'h123; read 0x0C/0x0D; change angle_in to 12'hFFF after the first byte.
  - Required: reads 8'h01, 8'h23.
- **Pointer auto-increment:** pointer 0x0B, 4-byte read with angle 12'h5A7.
  - Required: 8'h20, 8'h05, 8'hA7, 8'h05.
  - Then a second read with no pointer write, 1 byte: 8'hA7 (from 0x0F).
- **Register write ignored:** write 6C, 0C, 8'h55.
  - Required: all bytes ACKed; reg_ptr=8'h0C; a subsequent read of 0x0C is unaffected by the 8'h55.
- **Reset mid-read:** reset_n low while the target is driving a 0 data bit.
  - Required: sda Z in the same cycle; reg_ptr=8'h00.
  - The next transaction decodes normally.

Source files
------------

// File: rtl/as5600_target.sv
// I2C target that emulates the AS5600 angle read path.
// Supports a pointer write, coherent angle snapshot reads, and auto-incrementing reads.
module as5600_target #(
    parameter logic [6:0] DEV_ADDR = 7'h36
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [11:0] angle_in,
    input  logic        angle_valid,
    input  logic        scl,
    inout  wire         sda,
    output logic        busy,
    output logic        rd_done,
    output logic [7:0]  reg_ptr
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WR_DISCARD, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  scl_sync, sda_sync;
    logic        scl_s, sda_s, scl_d, sda_d;
    logic        scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic [7:0]  reg_ptr_nxt;
    logic [7:0]  rd_byte;
    logic [11:0] live, snap;
    logic        snap_load;
    logic        sda_low, sda_low_nxt;
    logic        busy_nxt;
    logic        nack, nack_nxt;
    logic        byte_read, byte_read_nxt;
    logic        rd_done_nxt;

    // Open drain: the pad is only ever pulled low or released.
    assign sda = sda_low ? 1'b0 : 1'bz;

    // The synchronizer resets to the idle-bus level, so reset release cannot fake a START.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    always_comb begin
        // NOTE: a default comes before the case so that no latch is inferred.
        rd_byte = 8'h00;
        case (reg_ptr)
            8'h0B:        rd_byte = 8'h20;
            8'h0C, 8'h0E: rd_byte = {4'h0, snap[11:8]};
            8'h0D, 8'h0F: rd_byte = snap[7:0];
            default:      rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shreg_nxt     = shreg;
        reg_ptr_nxt   = reg_ptr;
        sda_low_nxt   = sda_low;
        busy_nxt      = busy;
        nack_nxt      = nack;
        byte_read_nxt = byte_read;
        rd_done_nxt   = 1'b0;
        snap_load     = 1'b0;
        // Bus conditions take priority over any bit activity in the same cycle.
        if (start_det) begin
            state_nxt     = ADDR;
            bit_cnt_nxt   = 4'd0;
            sda_low_nxt   = 1'b0;
            busy_nxt      = 1'b0;
            byte_read_nxt = 1'b0;
        end else if (stop_det) begin
            state_nxt     = IDLE;
            sda_low_nxt   = 1'b0;
            busy_nxt      = 1'b0;
            byte_read_nxt = 1'b0;
            rd_done_nxt   = byte_read;
        end else begin
            case (state)
                ADDR, REG, WR_DISCARD: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        shreg_nxt   = {shreg[6:0], sda_s};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt_nxt = 4'd0;
                        if (state == ADDR) begin
                            if (shreg[7:1] == DEV_ADDR) begin
                                state_nxt   = ADDR_ACK;
                                sda_low_nxt = 1'b1;
                                busy_nxt    = 1'b1;
                                snap_load   = shreg[0];
                            end else begin
                                state_nxt = IGNORE;
                            end
                        end else if (state == REG) begin
                            reg_ptr_nxt = shreg;
                            state_nxt   = REG_ACK;
                            sda_low_nxt = 1'b1;
                        end else begin
                            state_nxt   = WR_ACK;
                            sda_low_nxt = 1'b1;
                        end
                    end
                end
                ADDR_ACK, REG_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        sda_low_nxt = 1'b0;
                        bit_cnt_nxt = 4'd0;
                        if (state == ADDR_ACK && shreg[0]) begin
                            state_nxt   = RD_DATA;
                            shreg_nxt   = rd_byte;
                            sda_low_nxt = ~rd_byte[7];
                        end else if (state == ADDR_ACK) begin
                            state_nxt = REG;
                        end else begin
                            state_nxt = WR_DISCARD;
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd7) begin
                            state_nxt     = RD_ACK;
                            sda_low_nxt   = 1'b0;
                            bit_cnt_nxt   = 4'd0;
                            reg_ptr_nxt   = reg_ptr + 8'd1;
                            byte_read_nxt = 1'b1;
                        end else begin
                            shreg_nxt   = {shreg[6:0], 1'b0};
                            sda_low_nxt = ~shreg[6];
                            bit_cnt_nxt = bit_cnt + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        nack_nxt = sda_s;
                    end else if (scl_fall) begin
                        if (nack) begin
                            state_nxt = IGNORE;
                        end else begin
                            state_nxt   = RD_DATA;
                            shreg_nxt   = rd_byte;
                            sda_low_nxt = ~rd_byte[7];
                            bit_cnt_nxt = 4'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            shreg     <= 8'h00;
            reg_ptr   <= 8'h00;
            sda_low   <= 1'b0;
            busy      <= 1'b0;
            nack      <= 1'b0;
            byte_read <= 1'b0;
            rd_done   <= 1'b0;
            live      <= 12'h000;
            snap      <= 12'h000;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            reg_ptr   <= reg_ptr_nxt;
            sda_low   <= sda_low_nxt;
            busy      <= busy_nxt;
            nack      <= nack_nxt;
            byte_read <= byte_read_nxt;
            rd_done   <= rd_done_nxt;
            if (angle_valid) live <= angle_in;
            if (snap_load)   snap <= live;
        end
    end

endmodule

// File: tb/tb_as5600_target.sv
// Directed bench for as5600_target: a bit-banged I2C initiator plus a
// transaction-level register-map model.
module tb_as5600_target;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        scl = 1'b1;
    logic        m_sda_low = 1'b0;
    logic [11:0] angle_in = 12'h000;
    logic        angle_valid = 1'b0;
    wire         sda;
    logic        busy, rd_done;
    logic [7:0]  reg_ptr;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    always #5 clock = ~clock;

    as5600_target #(.DEV_ADDR(7'h36)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .angle_in   (angle_in),
        .angle_valid(angle_valid),
        .scl        (scl),
        .sda        (sda),
        .busy       (busy),
        .rd_done    (rd_done),
        .reg_ptr    (reg_ptr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: live angle, read snapshot, register pointer.
    logic [11:0] m_live = 12'h000;
    logic [11:0] m_snap = 12'h000;
    logic [7:0]  m_ptr  = 8'h00;

    logic idle_chk  = 1'b0;
    logic quiet_chk = 1'b0;
    int   rd_pulses = 0;

    function automatic logic [7:0] m_reg(input logic [7:0] a);
        logic [15:0] angle16;
        angle16 = {4'h0, m_snap};
        if (a == 8'h0B) return 8'h20;
        if (a >= 8'h0C && a <= 8'h0F) return a[0] ? angle16[7:0] : angle16[15:8];
        return 8'h00;
    endfunction

    function automatic logic line();
        return (sda === 1'b0) ? 1'b0 : 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Compare process: idle-bus pointer/busy against the model, quiet-bus sda, rd_done pulses.
    always @(negedge clock) begin
        if (reset_n) begin
            if (rd_done) rd_pulses++;
            if (idle_chk) begin
                n_checks++;
                if (reg_ptr !== m_ptr || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_state: reg_ptr=%0h busy=%0b expected reg_ptr=%0h busy=0",
                             reg_ptr, busy, m_ptr);
                end
            end
            if (quiet_chk) begin
                n_checks++;
                if (busy !== 1'b0 || (!m_sda_low && sda === 1'b0)) begin
                    n_fail++;
                    $display("FAIL quiet_bus: busy=%0b sda=%0b expected busy=0 sda released", busy, sda);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b, output logic s);
        scl = 1'b0;
        tick(4);
        m_sda_low = ~b;
        tick(4);
        scl = 1'b1;
        tick(7);
        s = line();
        tick(1);
    endtask

    task automatic i2c_start();
        idle_chk = 1'b0;
        m_sda_low = 1'b1;
        tick(8);
    endtask

    task automatic i2c_rstart();
        scl = 1'b0;
        tick(4);
        m_sda_low = 1'b0;
        tick(4);
        scl = 1'b1;
        tick(8);
        m_sda_low = 1'b1;
        tick(8);
    endtask

    task automatic i2c_stop();
        scl = 1'b0;
        tick(4);
        m_sda_low = 1'b1;
        tick(4);
        scl = 1'b1;
        tick(8);
        m_sda_low = 1'b0;
        tick(8);
        idle_chk = 1'b1;
    endtask

    task automatic wr_byte(input string name, input logic [7:0] b, input logic exp_ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, s);
        check(name, {31'b0, ~s}, {31'b0, exp_ack});
    endtask

    task automatic rd_byte(input string name, input logic [7:0] lit, input logic m_ack);
        logic       s;
        logic [7:0] got;
        logic [7:0] exp;
        exp   = m_reg(m_ptr);
        m_ptr = m_ptr + 8'd1;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            got[i] = s;
        end
        send_bit(~m_ack, s);
        check({name, "_model"}, {24'b0, got}, {24'b0, exp});
        check({name, "_literal"}, {24'b0, got}, {24'b0, lit});
    endtask

    task automatic set_angle(input logic [11:0] a);
        angle_in = a;
        m_live   = a;
        tick(2);
    endtask

    task automatic write_ptr(input string name, input logic [7:0] p);
        i2c_start();
        wr_byte({name, "_hdr_w"}, 8'h6C, 1'b1);
        wr_byte({name, "_ptr"}, p, 1'b1);
        m_ptr = p;
    endtask

    task automatic read_hdr(input string name);
        wr_byte({name, "_hdr_r"}, 8'h6D, 1'b1);
        m_snap = m_live;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;

        tick(3);
        check("reset_sda", {31'b0, line()}, 32'd1);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_rd_done", {31'b0, rd_done}, 32'd0);
        check("reset_reg_ptr", {24'b0, reg_ptr}, 32'h00);
        reset_n = 1'b1;
        angle_valid = 1'b1;
        tick(4);
        idle_chk = 1'b1;

        // Pointer write then read across a repeated START.
        set_angle(12'hABC);
        p0 = rd_pulses;
        write_ptr("t1", 8'h0C);
        i2c_rstart();
        read_hdr("t1");
        rd_byte("t1_b0", 8'h0A, 1'b1);
        check("t1_busy_mid", {31'b0, busy}, 32'd1);
        rd_byte("t1_b1", 8'hBC, 1'b0);
        i2c_stop();
        check("t1_rd_done_count", rd_pulses - p0, 32'd1);
        check("t1_reg_ptr", {24'b0, reg_ptr}, 32'h0E);

        // Wrong address: no ACK, sda untouched, busy stays low.
        idle_chk = 1'b0;
        quiet_chk = 1'b1;
        i2c_start();
        wr_byte("t2_wrong_addr_ack", 8'hA0, 1'b0);
        i2c_stop();
        quiet_chk = 1'b0;

        // Snapshot coherence: angle changes between the two byte reads.
        set_angle(12'h123);
        write_ptr("t3", 8'h0C);
        i2c_rstart();
        read_hdr("t3");
        rd_byte("t3_b0", 8'h01, 1'b1);
        angle_in = 12'hFFF;
        m_live   = 12'hFFF;
        rd_byte("t3_b1", 8'h23, 1'b0);
        i2c_stop();

        // Pointer auto-increment, then a continued read with no pointer write.
        set_angle(12'h5A7);
        write_ptr("t4", 8'h0B);
        i2c_rstart();
        read_hdr("t4");
        rd_byte("t4_b0", 8'h20, 1'b1);
        rd_byte("t4_b1", 8'h05, 1'b1);
        rd_byte("t4_b2", 8'hA7, 1'b1);
        rd_byte("t4_b3", 8'h05, 1'b0);
        i2c_stop();
        i2c_start();
        read_hdr("t4b");
        rd_byte("t4b_b0", 8'hA7, 1'b0);
        i2c_stop();
        check("t4_reg_ptr", {24'b0, reg_ptr}, 32'h10);

        // Register write is acknowledged and discarded; no rd_done on a write-only transfer.
        p0 = rd_pulses;
        write_ptr("t5", 8'h0C);
        wr_byte("t5_data_ack", 8'h55, 1'b1);
        i2c_stop();
        check("t5_reg_ptr", {24'b0, reg_ptr}, 32'h0C);
        check("t5_no_rd_done", rd_pulses - p0, 32'd0);
        i2c_start();
        read_hdr("t5");
        rd_byte("t5_b0", 8'h05, 1'b0);
        i2c_stop();

        // Pointer wraps from 8'hFF to 8'h00.
        write_ptr("t6", 8'hFF);
        i2c_rstart();
        read_hdr("t6");
        rd_byte("t6_b0", 8'h00, 1'b1);
        rd_byte("t6_b1", 8'h00, 1'b0);
        i2c_stop();
        check("t6_reg_ptr", {24'b0, reg_ptr}, 32'h01);

        // Reset while the target drives a 0 data bit (bit 7 of 8'h20).
        write_ptr("t7", 8'h0B);
        i2c_rstart();
        read_hdr("t7");
        scl = 1'b0;
        tick(6);
        check("t7_driving_zero", {31'b0, line()}, 32'd0);
        #2;
        reset_n = 1'b0;
        m_ptr   = 8'h00;
        m_snap  = 12'h000;
        #1;
        check("t7_sda_released", {31'b0, line()}, 32'd1);
        check("t7_reg_ptr", {24'b0, reg_ptr}, 32'h00);
        check("t7_busy", {31'b0, busy}, 32'd0);
        tick(2);
        scl = 1'b1;
        tick(4);
        reset_n = 1'b1;
        tick(4);
        idle_chk = 1'b1;

        // Normal decode after the reset.
        write_ptr("t8", 8'h0D);
        i2c_rstart();
        read_hdr("t8");
        rd_byte("t8_b0", 8'hA7, 1'b0);
        i2c_stop();
        check("t8_reg_ptr", {24'b0, reg_ptr}, 32'h0E);

        idle_chk = 1'b0;
        tick(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
